// File: rtl/load_use_hazard_unit.sv
// Load-use hazard unit: per-register in-flight write scoreboard plus a load-age timer that stalls ID.
// Build with HAZARD_PERF_EN defined to add the stall-cycle and load-issue performance counters.
module load_use_hazard_unit #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [4:0]          id_Rs1_in,
  input  logic [4:0]          id_Rs2_in,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [4:0]          id_Rd_in,
  input  logic                id_RegWrite,
  input  logic                id_MemRead,
  input  logic                id_advance,
  input  logic                ex_kill,
  input  logic [4:0]          ex_kill_Rd,
  input  logic                ex_kill_RegWrite,
  input  logic                wb_RegWrite_in,
  input  logic [4:0]          wb_Rd_in,
  output logic                stall_out,
  output logic                issue_out,
  output logic [NUM_REGS-1:0] pending_mask_out,
  output logic                sb_error_out
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         stall_cycles_out,
  output logic [31:0]         load_issue_cnt_out
`endif
);
  localparam int         CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [1:0] LAT     = 2'(LOAD_LAT);

  logic [CNT_W-1:0] pend_cnt [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];
  logic [1:0]       ld_timer;
  logic [4:0]       ld_rd;
  logic             err_next;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             load_issue;
  int               nxt;

  // ID->EX transfer happens only on issue_out = id_valid & id_advance & ~stall_out;
  // stall_out is the not-ready side and holds the instruction in ID.
  assign rs1_hit    = id_use_rs1 && (id_Rs1_in == ld_rd);
  assign rs2_hit    = id_use_rs2 && (id_Rs2_in == ld_rd);
  assign stall_out  = id_valid && (ld_timer != 2'd0) && (ld_rd != 5'd0) && (rs1_hit || rs2_hit);
  assign issue_out  = id_valid && id_advance && !stall_out;
  assign load_issue = issue_out && id_MemRead && id_RegWrite && (id_Rd_in != 5'd0);

  always_comb begin
    err_next         = 1'b0;
    nxt              = 0;
    pending_mask_out = '0;
    for (int r = 0; r < NUM_REGS; r++) cnt_next[r] = pend_cnt[r];
    for (int r = 1; r < NUM_REGS; r++) begin
      nxt = int'(pend_cnt[r])
          + int'(issue_out && id_RegWrite && (id_Rd_in == 5'(r)))
          - int'(wb_RegWrite_in && (wb_Rd_in == 5'(r)))
          - int'(ex_kill && ex_kill_RegWrite && (ex_kill_Rd == 5'(r)));
      // Out-of-range results hold the current bound and flag the scoreboard as corrupt.
      if (nxt > CNT_MAX) begin
        err_next = 1'b1;
      end else if (nxt < 0) begin
        cnt_next[r] = '0;
        err_next    = 1'b1;
      end else begin
        cnt_next[r] = CNT_W'(nxt);
      end
      pending_mask_out[r] = (pend_cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend_cnt[r] <= '0;
      ld_timer     <= 2'd0;
      ld_rd        <= 5'd0;
      sb_error_out <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pend_cnt[r] <= cnt_next[r];
      if (err_next) sb_error_out <= 1'b1;
      if (ex_kill) begin
        ld_timer <= 2'd0;
      end else if (load_issue) begin
        ld_timer <= LAT;
        ld_rd    <= id_Rd_in;
      end else if (ld_timer != 2'd0) begin
        ld_timer <= ld_timer - 2'd1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_out   <= 32'd0;
      load_issue_cnt_out <= 32'd0;
    end else begin
      if (stall_out) stall_cycles_out <= stall_cycles_out + 32'd1;
      if (issue_out && id_MemRead) load_issue_cnt_out <= load_issue_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Bench for load_use_hazard_unit: directed vector table, hand corner sequences, random vs. reference model.
module tb_load_use_hazard_unit;
  localparam int LAT = 1;

  typedef struct {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic [4:0] rd; logic rw; logic mr; logic adv;
    logic kill; logic [4:0] krd; logic krw;
    logic wbw; logic [4:0] wbrd;
  } in_t;

  typedef struct {
    in_t i; logic stall; logic issue; logic [31:0] mask; logic err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  in_t  cur;
  logic stall_out, issue_out, sb_error_out;
  logic [31:0] pending_mask_out;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_out, load_issue_cnt_out;
`endif

  always #5 clk = ~clk;

  load_use_hazard_unit #(.NUM_REGS(32), .CNT_W(2), .LOAD_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(cur.v), .id_Rs1_in(cur.rs1), .id_Rs2_in(cur.rs2),
    .id_use_rs1(cur.u1), .id_use_rs2(cur.u2), .id_Rd_in(cur.rd),
    .id_RegWrite(cur.rw), .id_MemRead(cur.mr), .id_advance(cur.adv),
    .ex_kill(cur.kill), .ex_kill_Rd(cur.krd), .ex_kill_RegWrite(cur.krw),
    .wb_RegWrite_in(cur.wbw), .wb_Rd_in(cur.wbrd),
    .stall_out(stall_out), .issue_out(issue_out),
    .pending_mask_out(pending_mask_out), .sb_error_out(sb_error_out)
`ifdef HAZARD_PERF_EN
    , .stall_cycles_out(stall_cycles_out), .load_issue_cnt_out(load_issue_cnt_out)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int m_cnt [32];
  int m_left, m_reg, m_stalls, m_loads;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic void m_reset();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_left = 0; m_reg = 0; m_err = 0; m_stalls = 0; m_loads = 0;
  endfunction

  function automatic bit m_stall();
    return cur.v && m_left != 0 && m_reg != 0 &&
           ((cur.u1 && int'(cur.rs1) == m_reg) || (cur.u2 && int'(cur.rs2) == m_reg));
  endfunction

  function automatic bit m_issue();
    return cur.v && cur.adv && !m_stall();
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) m[r] = 1'b1;
    return m;
  endfunction

  // Register-write bookkeeping: a write counts up when it leaves ID and down when it retires or is killed.
  function automatic void m_step();
    bit iss = m_issue();
    if (m_stall()) m_stalls++;
    if (iss && cur.mr) m_loads++;
    for (int r = 1; r < 32; r++) begin
      int n = m_cnt[r];
      if (iss && cur.rw && int'(cur.rd) == r) n++;
      if (cur.wbw && int'(cur.wbrd) == r) n--;
      if (cur.kill && cur.krw && int'(cur.krd) == r) n--;
      if (n > 3) begin n = 3; m_err = 1; end
      if (n < 0) begin n = 0; m_err = 1; end
      m_cnt[r] = n;
    end
    if (cur.kill) m_left = 0;
    else if (iss && cur.mr && cur.rw && cur.rd != 0) begin m_left = LAT; m_reg = int'(cur.rd); end
    else if (m_left > 0) m_left--;
  endfunction

  // ---------------- driver ----------------
  function automatic in_t idle();
    in_t t;
    t.v = 0; t.rs1 = 0; t.rs2 = 0; t.u1 = 0; t.u2 = 0; t.rd = 0; t.rw = 0; t.mr = 0;
    t.adv = 1; t.kill = 0; t.krd = 0; t.krw = 0; t.wbw = 0; t.wbrd = 0;
    return t;
  endfunction

  function automatic in_t ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
    in_t t = idle();
    t.v = 1; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd; t.rw = rw; t.mr = mr;
    return t;
  endfunction

  function automatic in_t wb(input in_t b, input logic [4:0] r);
    in_t t = b;
    t.wbw = 1; t.wbrd = r;
    return t;
  endfunction

  // Called at a falling edge with cur already set; checks outputs, then advances one cycle.
  task automatic tick();
    #1;
    chk("stall", 32'(stall_out), 32'(m_stall()));
    chk("issue", 32'(issue_out), 32'(m_issue()));
    chk("mask", pending_mask_out, m_mask());
    chk("err", 32'(sb_error_out), 32'(m_err));
`ifdef HAZARD_PERF_EN
    chk("stall_cycles", stall_cycles_out, 32'(m_stalls));
    chk("load_issues", load_issue_cnt_out, 32'(m_loads));
`endif
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cur = idle();
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t tbl [11];
  localparam logic [31:0] M5 = 32'h20, M6 = 32'h40, M10 = 32'h400, M11 = 32'h800;

  initial begin
    cur = idle();
    m_reset();
    tbl[0]  = '{ins(1, 0, 1, 0, 5, 1, 1),    0, 1, 32'h0,            0};
    tbl[1]  = '{ins(5, 7, 1, 1, 6, 1, 0),    1, 0, M5,               0};
    tbl[2]  = '{ins(5, 7, 1, 1, 6, 1, 0),    0, 1, M5,               0};
    tbl[3]  = '{ins(0, 0, 0, 0, 5, 1, 1),    0, 1, M5 | M6,          0};
    tbl[4]  = '{ins(0, 5, 1, 0, 10, 1, 0),   0, 1, M5 | M6,          0};
    tbl[5]  = '{ins(0, 0, 0, 0, 0, 1, 1),    0, 1, M5 | M6 | M10,    0};
    tbl[6]  = '{ins(0, 0, 1, 1, 11, 1, 0),   0, 1, M5 | M6 | M10,    0};
    tbl[7]  = '{wb(idle(), 5),               0, 0, M5|M6|M10|M11,    0};
    tbl[8]  = '{wb(idle(), 5),               0, 0, M5|M6|M10|M11,    0};
    tbl[9]  = '{wb(ins(0,0,0,0,6,1,0), 6),   0, 1, M6 | M10 | M11,   0};
    tbl[10] = '{idle(),                      0, 0, M6 | M10 | M11,   0};

    do_reset();
    #1;
    chk("reset_stall", 32'(stall_out), 32'h0);
    chk("reset_mask", pending_mask_out, 32'h0);
    chk("reset_err", 32'(sb_error_out), 32'h0);
    @(negedge clk);

    // Load-use, no-false-stall and retire/issue overlap vectors.
    for (int k = 0; k < 11; k++) begin
      cur = tbl[k].i;
      #1;
      chk($sformatf("tbl%0d_stall", k), 32'(stall_out), 32'(tbl[k].stall));
      chk($sformatf("tbl%0d_issue", k), 32'(issue_out), 32'(tbl[k].issue));
      chk($sformatf("tbl%0d_mask", k), pending_mask_out, tbl[k].mask);
      chk($sformatf("tbl%0d_err", k), 32'(sb_error_out), 32'(tbl[k].err));
      tick();
    end

    // Kill of an in-flight load while its dependent waits in ID.
    do_reset();
    cur = ins(0, 0, 0, 0, 8, 1, 1); tick();
    cur = ins(8, 0, 1, 0, 12, 1, 0);
    cur.kill = 1; cur.krd = 8; cur.krw = 1;
    #1 chk("kill_pre_stall", 32'(stall_out), 32'h1);
    tick();
    cur = ins(8, 0, 1, 0, 12, 1, 0);
    #1;
    chk("kill_stall", 32'(stall_out), 32'h0);
    chk("kill_issue", 32'(issue_out), 32'h1);
    chk("kill_mask", pending_mask_out, 32'h0);
    chk("kill_err", 32'(sb_error_out), 32'h0);
    tick();

    // Retire and issue to x3 in the same cycle cancel.
    do_reset();
    cur = ins(0, 0, 0, 0, 3, 1, 0); tick();
    cur = wb(ins(0, 0, 0, 0, 3, 1, 0), 3); tick();
    cur = idle();
    #1 chk("overlap_mask", pending_mask_out, 32'h8);
    tick();
    cur = wb(idle(), 3); tick();
    cur = idle();
    #1 chk("overlap_drain", pending_mask_out, 32'h0);
    chk("overlap_err", 32'(sb_error_out), 32'h0);
    tick();

    // Underflow on an idle register.
    do_reset();
    cur = wb(idle(), 4); tick();
    cur = idle();
    #1 chk("underflow_err", 32'(sb_error_out), 32'h1);
    chk("underflow_mask", pending_mask_out, 32'h0);
    tick();

    // Saturation at 3: four writes, then exactly three retires drain it.
    do_reset();
    repeat (4) begin cur = ins(0, 0, 0, 0, 9, 1, 0); tick(); end
    cur = idle();
    #1 chk("sat_err", 32'(sb_error_out), 32'h1);
    chk("sat_mask", pending_mask_out, 32'h200);
    tick();
    repeat (2) begin cur = wb(idle(), 9); tick(); end
    cur = idle();
    #1 chk("sat_hold3", pending_mask_out, 32'h200);
    cur = wb(idle(), 9); tick();
    cur = idle();
    #1 chk("sat_drain", pending_mask_out, 32'h0);
    chk("sat_sticky", 32'(sb_error_out), 32'h1);
    tick();

    // Asynchronous reset while a dependent is stalled.
    cur = ins(0, 0, 0, 0, 5, 1, 1); tick();
    cur = ins(5, 7, 1, 1, 6, 1, 0);
    #1 chk("rst_pre_stall", 32'(stall_out), 32'h1);
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("rst_async_stall", 32'(stall_out), 32'h0);
    chk("rst_async_mask", pending_mask_out, 32'h0);
    chk("rst_async_err", 32'(sb_error_out), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst_release_issue", 32'(issue_out), 32'h1);
    tick();

    // Randomized traffic over a small register window to force collisions.
    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 0) do_reset();
      cur.v    = ($urandom_range(0, 3) != 0);
      cur.rs1  = 5'($urandom_range(0, 7));
      cur.rs2  = 5'($urandom_range(0, 7));
      cur.u1   = 1'($urandom_range(0, 1));
      cur.u2   = 1'($urandom_range(0, 1));
      cur.rd   = 5'($urandom_range(0, 7));
      cur.rw   = ($urandom_range(0, 3) != 0);
      cur.mr   = ($urandom_range(0, 2) == 0);
      cur.adv  = ($urandom_range(0, 3) != 0);
      cur.kill = ($urandom_range(0, 15) == 0);
      cur.krd  = 5'($urandom_range(0, 7));
      cur.krw  = 1'($urandom_range(0, 1));
      cur.wbw  = ($urandom_range(0, 2) == 0);
      cur.wbrd = 5'($urandom_range(0, 7));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
